// File: rtl/force_accum_receiver.sv
// Force writeback receiver: buffers ring packets and accumulates them into a per-particle store.
// Optional FORCE_ACC_SATURATE_EN makes each component add saturate instead of wrapping.
module force_accum_receiver #(
    parameter int unsigned DATA_WIDTH        = 32,
    parameter int unsigned PARTICLE_ID_WIDTH = 7,
    parameter int unsigned DEPTH             = 100,
    parameter int unsigned FIFO_DEPTH        = 8
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       in_valid,
    input  logic [PARTICLE_ID_WIDTH+3*DATA_WIDTH-1:0]  in_data,
    output logic                                       in_ready,
    input  logic                                       clear,
    input  logic                                       mu_rd_en,
    input  logic [PARTICLE_ID_WIDTH-1:0]               mu_rd_addr,
    output logic [3*DATA_WIDTH-1:0]                    mu_force_out,
    output logic                                       mu_force_valid,
    output logic                                       idle,
    output logic [1:0]                                 err_flags
);

    localparam int unsigned PW = PARTICLE_ID_WIDTH;
    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned FW = 3 * DATA_WIDTH;
    localparam int unsigned EW = PW + FW;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0]   DEPTH_ID  = DEPTH[PW:0];
    localparam logic [PW-1:0] LAST_ADDR = PW'(DEPTH - 1);

    typedef enum logic [1:0] {StRun, StClearWait, StClearing} state_e;

    state_e          state_q;
    logic [PW-1:0]   clr_cnt_q;
    logic            init_q;

    logic [EW-1:0]   fifo_mem [FIFO_DEPTH];
    logic [AW:0]     wr_ptr_q, rd_ptr_q;
    logic [FW-1:0]   mem [DEPTH];
    logic [FW-1:0]   rdata_q;

    logic            ex_valid_q, wb_valid_q, ret_valid_q;
    logic [PW-1:0]   ex_id_q, wb_id_q, ret_id_q;
    logic [FW-1:0]   ex_f_q, wb_sum_q, ret_sum_q;
    logic            mu_valid_q;
    logic [1:0]      err_q;

    logic            empty, full, push, pop, stall_same, running, clearing, pipe_busy;
    logic [EW-1:0]   head;
    logic [PW-1:0]   head_id, rd_addr, mem_waddr;
    logic            head_id_ok, rd_en, rd_addr_ok, mem_we;
    logic [FW-1:0]   ex_base, ex_sum, mem_wdata;

    function automatic logic [DW-1:0] add_comp(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] s;
        s = a + b;
`ifdef FORCE_ACC_SATURATE_EN
        if ((a[DW-1] == b[DW-1]) && (s[DW-1] != a[DW-1])) begin
            s = a[DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end
`endif
        return s;
    endfunction

    always_comb begin
        empty      = (wr_ptr_q == rd_ptr_q);
        full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        head       = fifo_mem[rd_ptr_q[AW-1:0]];
        head_id    = head[PW-1:0];
        head_id_ok = ({1'b0, head_id} < DEPTH_ID);
        running    = (state_q == StRun);
        clearing   = (state_q == StClearing);
        pipe_busy  = ex_valid_q | wb_valid_q;

        in_ready   = init_q & ~full & ~clearing;
        push       = in_valid & in_ready;
        stall_same = ex_valid_q & (head_id == ex_id_q);
        // A clear pulse also blocks the pop so the drain check sees a quiet pipeline.
        pop        = ~empty & ~stall_same & ~mu_rd_en & running & ~clear;

        rd_en      = mu_rd_en | (pop & head_id_ok);
        rd_addr    = mu_rd_en ? mu_rd_addr : head_id;
        rd_addr_ok = ({1'b0, rd_addr} < DEPTH_ID);

        // The store read was issued while older writes were in flight, so forward them.
        if (wb_valid_q && (wb_id_q == ex_id_q)) begin
            ex_base = wb_sum_q;
        end else if (ret_valid_q && (ret_id_q == ex_id_q)) begin
            ex_base = ret_sum_q;
        end else begin
            ex_base = rdata_q;
        end
        ex_sum = '0;
        for (int i = 0; i < 3; i++) begin
            ex_sum[i*DW +: DW] = add_comp(ex_base[i*DW +: DW], ex_f_q[i*DW +: DW]);
        end

        mem_we    = clearing | wb_valid_q;
        mem_waddr = clearing ? clr_cnt_q : wb_id_q;
        mem_wdata = clearing ? '0 : wb_sum_q;

        idle           = empty & ~pipe_busy & running;
        mu_force_out   = rdata_q;
        mu_force_valid = mu_valid_q;
        err_flags      = err_q;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= in_data;
        end
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StRun;
            clr_cnt_q   <= '0;
            init_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rdata_q     <= '0;
            ex_valid_q  <= 1'b0;
            ex_id_q     <= '0;
            ex_f_q      <= '0;
            wb_valid_q  <= 1'b0;
            wb_id_q     <= '0;
            wb_sum_q    <= '0;
            ret_valid_q <= 1'b0;
            ret_id_q    <= '0;
            ret_sum_q   <= '0;
            mu_valid_q  <= 1'b0;
            err_q       <= '0;
        end else begin
            init_q <= 1'b1;

            unique case (state_q)
                StRun: begin
                    if (clear) begin
                        state_q   <= pipe_busy ? StClearWait : StClearing;
                        clr_cnt_q <= '0;
                    end
                end
                StClearWait: begin
                    if (!pipe_busy) begin
                        state_q   <= StClearing;
                        clr_cnt_q <= '0;
                    end
                end
                StClearing: begin
                    if (clear) begin
                        clr_cnt_q <= '0;
                    end else if (clr_cnt_q == LAST_ADDR) begin
                        state_q <= StRun;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + 1'b1;
                    end
                end
                default: state_q <= StRun;
            endcase

            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;

            if (rd_en) begin
                rdata_q <= rd_addr_ok ? mem[rd_addr] : '0;
            end
            mu_valid_q <= mu_rd_en;

            ex_valid_q <= pop & head_id_ok;
            if (pop) begin
                ex_id_q <= head_id;
                ex_f_q  <= head[EW-1:PW];
            end

            wb_valid_q <= ex_valid_q;
            wb_id_q    <= ex_id_q;
            wb_sum_q   <= ex_sum;

            if (clearing) begin
                ret_valid_q <= 1'b0;
            end else if (wb_valid_q) begin
                ret_valid_q <= 1'b1;
                ret_id_q    <= wb_id_q;
                ret_sum_q   <= wb_sum_q;
            end

            if (in_valid && !in_ready) err_q[0] <= 1'b1;
            if (pop && !head_id_ok)    err_q[1] <= 1'b1;
        end
    end

endmodule
